// File: rtl/flash_if_pkg.sv
// Shared definitions for the flash read responder and the flash reader.
// Holds the handshake state encoding, default bus widths and the wait-counter type.
// No logic; compile before any user of these types.
package flash_if_pkg;

  localparam int FLASH_ADDR_W  = 23;
  localparam int FLASH_DATA_W  = 32;
  localparam int FLASH_BURST_W = 6;

  // Wait counter is wide enough for the 0..15 legal range of WAIT_CYCLES.
  localparam int WAIT_CNT_W = 4;
  typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCEPT = 2'd2,
    S_STREAM = 2'd3
  } flash_state_t;

endpackage

// File: rtl/flash_rd_return_pipe.sv
// Read-return stage: turns the per-cycle ROM issue strobe into readdatavalid/burst_done.
// Latency: valid and burst_done follow the issue strobe by exactly one cycle.
// No backpressure: every issued word is returned; readdata holds between valid words.
module flash_rd_return_pipe #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue,
  input  logic              last,
  input  logic [DATA_W-1:0] rom_rdata,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid,
  output logic              burst_done
);

  logic              vld_q;
  logic              done_q;
  logic [DATA_W-1:0] hold_q;

  // Delay the issue strobe one cycle to line up with the ROM's registered output,
  // and remember the last returned word so readdata is stable between valids.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q  <= 1'b0;
      done_q <= 1'b0;
      hold_q <= '0;
    end else begin
      vld_q  <= issue;
      done_q <= issue & last;
      if (vld_q) begin
        hold_q <= rom_rdata;
      end
    end
  end

  // The synchronous ROM already registers its data, so it passes straight through
  // on valid cycles; otherwise the last returned word is presented.
  assign readdata      = vld_q ? rom_rdata : hold_q;
  assign readdatavalid = vld_q;
  assign burst_done    = done_q;

endmodule

// File: rtl/flash_read_responder.sv
// Avalon-MM burst read slave in front of a synchronous ROM (IDLE/WAIT/ACCEPT/STREAM).
// Latency: waitrequest low WAIT_CYCLES+1 after read; first word 2 cycles after accept.
// Backpressure: waitrequest high except one ACCEPT cycle; accepted bursts never stall.
module flash_read_responder
  import flash_if_pkg::*;
#(
  parameter int ADDR_W      = FLASH_ADDR_W,
  parameter int DATA_W      = FLASH_DATA_W,
  parameter int BURST_W     = FLASH_BURST_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               avs_read,
  input  logic [ADDR_W-1:0]  avs_address,
  input  logic [BURST_W-1:0] avs_burstcount,
  output logic               avs_waitrequest,
  output logic [DATA_W-1:0]  avs_readdata,
  output logic               avs_readdatavalid,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_rdata,
  output logic               burst_done
);

  localparam wait_cnt_t WAIT_INIT = WAIT_CNT_W'(WAIT_CYCLES);

  flash_state_t       state;
  flash_state_t       state_nxt;
  wait_cnt_t          wait_cnt;
  logic [BURST_W-1:0] beats_left;
  logic               issue;
  logic               last_issue;

  // State register; reset drops any burst in flight straight back to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. The WAIT exit is taken on the cycle the counter steps to
  // zero, so exactly WAIT_CYCLES waitrequest-high cycles precede ACCEPT; with
  // WAIT_CYCLES=0 the WAIT state is skipped entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (avs_read) begin
          state_nxt = (WAIT_CYCLES == 0) ? S_ACCEPT : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!avs_read) begin
          state_nxt = S_IDLE;
        end else if (wait_cnt == wait_cnt_t'(1)) begin
          state_nxt = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        state_nxt = S_STREAM;
      end
      S_STREAM: begin
        if (beats_left == BURST_W'(1)) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from state: one ROM issue per STREAM cycle, waitrequest low only in ACCEPT.
  always_comb begin
    avs_waitrequest = (state != S_ACCEPT);
    issue           = (state == S_STREAM);
    last_issue      = (state == S_STREAM) && (beats_left == BURST_W'(1));
  end

  // Wait counter, captured burst length and ROM address walk.
  // rom_addr is loaded in ACCEPT so the first STREAM cycle already presents the
  // start address; it is not advanced past the final beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt   <= '0;
      beats_left <= '0;
      rom_addr   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (avs_read) begin
            wait_cnt <= WAIT_INIT;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - wait_cnt_t'(1);
        end
        S_ACCEPT: begin
          rom_addr   <= avs_address;
          beats_left <= (avs_burstcount == '0) ? BURST_W'(1) : avs_burstcount;
        end
        S_STREAM: begin
          beats_left <= beats_left - BURST_W'(1);
          if (beats_left != BURST_W'(1)) begin
            rom_addr <= rom_addr + ADDR_W'(1);
          end
        end
        default: begin
          wait_cnt <= '0;
        end
      endcase
    end
  end

  flash_rd_return_pipe #(
    .DATA_W(DATA_W)
  ) u_return_pipe (
    .clk          (clk),
    .reset        (reset),
    .issue        (issue),
    .last         (last_issue),
    .rom_rdata    (rom_rdata),
    .readdata     (avs_readdata),
    .readdatavalid(avs_readdatavalid),
    .burst_done   (burst_done)
  );

endmodule

// File: tb/tb_flash_read_responder.sv
// Directed bench for flash_read_responder: one instance with WAIT_CYCLES=2, one with 0.
// Inputs are driven and outputs sampled on the falling edge; ROM content is 0xA5000000|addr.
// Expected values are hand-computed from the cycle timeline of each scenario.
module tb_flash_read_responder;

  logic clk = 1'b0;
  logic reset;

  logic        a_read;
  logic [22:0] a_address;
  logic [5:0]  a_burstcount;
  logic        a_waitrequest;
  logic [31:0] a_readdata;
  logic        a_readdatavalid;
  logic [22:0] a_rom_addr;
  logic [31:0] a_rom_rdata = '0;
  logic        a_burst_done;

  logic        b_read;
  logic [22:0] b_address;
  logic [5:0]  b_burstcount;
  logic        b_waitrequest;
  logic [31:0] b_readdata;
  logic        b_readdatavalid;
  logic [22:0] b_rom_addr;
  logic [31:0] b_rom_rdata = '0;
  logic        b_burst_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  flash_read_responder #(
    .ADDR_W(23), .DATA_W(32), .BURST_W(6), .WAIT_CYCLES(2)
  ) dut_a (
    .clk              (clk),
    .reset            (reset),
    .avs_read         (a_read),
    .avs_address      (a_address),
    .avs_burstcount   (a_burstcount),
    .avs_waitrequest  (a_waitrequest),
    .avs_readdata     (a_readdata),
    .avs_readdatavalid(a_readdatavalid),
    .rom_addr         (a_rom_addr),
    .rom_rdata        (a_rom_rdata),
    .burst_done       (a_burst_done)
  );

  flash_read_responder #(
    .ADDR_W(23), .DATA_W(32), .BURST_W(6), .WAIT_CYCLES(0)
  ) dut_b (
    .clk              (clk),
    .reset            (reset),
    .avs_read         (b_read),
    .avs_address      (b_address),
    .avs_burstcount   (b_burstcount),
    .avs_waitrequest  (b_waitrequest),
    .avs_readdata     (b_readdata),
    .avs_readdatavalid(b_readdatavalid),
    .rom_addr         (b_rom_addr),
    .rom_rdata        (b_rom_rdata),
    .burst_done       (b_burst_done)
  );

  // Synchronous ROM models with one cycle of read latency.
  always @(posedge clk) a_rom_rdata <= 32'hA500_0000 | {9'd0, a_rom_addr};
  always @(posedge clk) b_rom_rdata <= 32'hA500_0000 | {9'd0, b_rom_addr};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    int wr_low;
    int vcnt;
    int dcnt;

    reset = 1'b1;
    a_read = 1'b0; a_address = '0; a_burstcount = '0;
    b_read = 1'b0; b_address = '0; b_burstcount = '0;

    // Reset values
    step();
    chk("rst_a_waitrequest", 32'(a_waitrequest), 32'd1);
    chk("rst_a_valid",       32'(a_readdatavalid), 32'd0);
    chk("rst_a_readdata",    a_readdata, 32'd0);
    chk("rst_a_rom_addr",    32'(a_rom_addr), 32'd0);
    chk("rst_a_burst_done",  32'(a_burst_done), 32'd0);
    chk("rst_b_waitrequest", 32'(b_waitrequest), 32'd1);
    reset = 1'b0;
    step();

    // Burst of 1 at 0x10, read sampled at cycle T
    a_read = 1'b1; a_address = 23'h000010; a_burstcount = 6'd1;
    step(); chk("b1_wr_T1", 32'(a_waitrequest), 32'd1);
    step(); chk("b1_wr_T2", 32'(a_waitrequest), 32'd1);
    step(); chk("b1_wr_T3", 32'(a_waitrequest), 32'd0);
    step(); a_read = 1'b0;
    chk("b1_wr_T4",    32'(a_waitrequest), 32'd1);
    chk("b1_valid_T4", 32'(a_readdatavalid), 32'd0);
    chk("b1_rom_T4",   32'(a_rom_addr), 32'h000010);
    step();
    chk("b1_valid_T5", 32'(a_readdatavalid), 32'd1);
    chk("b1_data_T5",  a_readdata, 32'hA500_0010);
    chk("b1_done_T5",  32'(a_burst_done), 32'd1);
    step();
    chk("b1_valid_T6", 32'(a_readdatavalid), 32'd0);
    chk("b1_done_T6",  32'(a_burst_done), 32'd0);
    chk("b1_hold_T6",  a_readdata, 32'hA500_0010);

    // Burst of 4 wrapping the address space; read toggles mid-stream
    a_read = 1'b1; a_address = 23'h7FFFFE; a_burstcount = 6'd4;
    step(); step();
    step(); chk("b4_wr_T3", 32'(a_waitrequest), 32'd0);
    step(); a_read = 1'b0;
    chk("b4_rom_T4", 32'(a_rom_addr), 32'h7FFFFE);
    step();
    chk("b4_rom_T5",   32'(a_rom_addr), 32'h7FFFFF);
    chk("b4_valid_T5", 32'(a_readdatavalid), 32'd1);
    chk("b4_data_T5",  a_readdata, 32'hA57F_FFFE);
    chk("b4_done_T5",  32'(a_burst_done), 32'd0);
    a_read = 1'b1; a_address = 23'h000055;
    step();
    chk("b4_rom_T6",   32'(a_rom_addr), 32'h000000);
    chk("b4_data_T6",  a_readdata, 32'hA57F_FFFF);
    chk("b4_done_T6",  32'(a_burst_done), 32'd0);
    a_read = 1'b0;
    step();
    chk("b4_rom_T7",   32'(a_rom_addr), 32'h000001);
    chk("b4_valid_T7", 32'(a_readdatavalid), 32'd1);
    chk("b4_data_T7",  a_readdata, 32'hA500_0000);
    chk("b4_done_T7",  32'(a_burst_done), 32'd0);
    step();
    chk("b4_valid_T8", 32'(a_readdatavalid), 32'd1);
    chk("b4_data_T8",  a_readdata, 32'hA500_0001);
    chk("b4_done_T8",  32'(a_burst_done), 32'd1);
    step();
    chk("b4_valid_T9", 32'(a_readdatavalid), 32'd0);
    chk("b4_hold_T9",  a_readdata, 32'hA500_0001);
    chk("b4_wr_T9",    32'(a_waitrequest), 32'd1);
    step();
    chk("b4_wr_T10",   32'(a_waitrequest), 32'd1);

    // burstcount 0 returns exactly one word
    a_read = 1'b1; a_address = 23'h000020; a_burstcount = 6'd0;
    step(); step();
    step(); chk("b0_wr_T3", 32'(a_waitrequest), 32'd0);
    step(); a_read = 1'b0;
    step();
    chk("b0_valid_T5", 32'(a_readdatavalid), 32'd1);
    chk("b0_data_T5",  a_readdata, 32'hA500_0020);
    chk("b0_done_T5",  32'(a_burst_done), 32'd1);
    step();
    chk("b0_valid_T6", 32'(a_readdatavalid), 32'd0);

    // Read dropped during WAIT aborts without data
    a_read = 1'b1; a_address = 23'h000030; a_burstcount = 6'd2;
    step();
    chk("ab_wr_T1", 32'(a_waitrequest), 32'd1);
    a_read = 1'b0;
    wr_low = 0; vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (a_waitrequest !== 1'b1) wr_low++;
      if (a_readdatavalid !== 1'b0) vcnt++;
    end
    chk("ab_wr_low_cycles", 32'(wr_low), 32'd0);
    chk("ab_valid_cycles",  32'(vcnt), 32'd0);

    // Reset on the second valid of an 8-word burst
    a_read = 1'b1; a_address = 23'h000100; a_burstcount = 6'd8;
    step(); step(); step();
    step(); a_read = 1'b0;
    step();
    chk("rb_valid_1st", 32'(a_readdatavalid), 32'd1);
    step();
    chk("rb_valid_2nd", 32'(a_readdatavalid), 32'd1);
    chk("rb_data_2nd",  a_readdata, 32'hA500_0101);
    reset = 1'b1;
    #1;
    chk("rb_rst_valid",    32'(a_readdatavalid), 32'd0);
    chk("rb_rst_data",     a_readdata, 32'd0);
    chk("rb_rst_wr",       32'(a_waitrequest), 32'd1);
    chk("rb_rst_rom_addr", 32'(a_rom_addr), 32'd0);
    chk("rb_rst_done",     32'(a_burst_done), 32'd0);
    step();
    reset = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (a_readdatavalid !== 1'b0) vcnt++;
    end
    chk("rb_valid_after_reset", 32'(vcnt), 32'd0);

    // WAIT_CYCLES=0: two back-to-back bursts of 2, read held high throughout
    b_read = 1'b1; b_address = 23'h000040; b_burstcount = 6'd2;
    vcnt = 0; dcnt = 0;
    step();
    chk("bb_wr_T1", 32'(b_waitrequest), 32'd0);
    step();
    b_address = 23'h000050;
    chk("bb_valid_T2", 32'(b_readdatavalid), 32'd0);
    step();
    if (b_readdatavalid === 1'b1) vcnt++;
    if (b_burst_done === 1'b1) dcnt++;
    chk("bb_data_T3", b_readdata, 32'hA500_0040);
    step();
    if (b_readdatavalid === 1'b1) vcnt++;
    if (b_burst_done === 1'b1) dcnt++;
    chk("bb_data_T4", b_readdata, 32'hA500_0041);
    chk("bb_done_T4", 32'(b_burst_done), 32'd1);
    step();
    if (b_readdatavalid === 1'b1) vcnt++;
    if (b_burst_done === 1'b1) dcnt++;
    chk("bb_wr_T5", 32'(b_waitrequest), 32'd0);
    step();
    b_read = 1'b0;
    if (b_readdatavalid === 1'b1) vcnt++;
    if (b_burst_done === 1'b1) dcnt++;
    step();
    if (b_readdatavalid === 1'b1) vcnt++;
    if (b_burst_done === 1'b1) dcnt++;
    chk("bb_data_T7", b_readdata, 32'hA500_0050);
    step();
    if (b_readdatavalid === 1'b1) vcnt++;
    if (b_burst_done === 1'b1) dcnt++;
    chk("bb_data_T8", b_readdata, 32'hA500_0051);
    for (int i = 0; i < 4; i++) begin
      step();
      if (b_readdatavalid === 1'b1) vcnt++;
      if (b_burst_done === 1'b1) dcnt++;
    end
    chk("bb_valid_total", 32'(vcnt), 32'd4);
    chk("bb_done_total",  32'(dcnt), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
